// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the uart_tx block.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int   MIN_PRESCALE = 4;
  localparam logic START_LEVEL  = 1'b0;
  localparam logic STOP_LEVEL   = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts CLK cycles within one bit and pulses bit_done on the last one.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);

  logic [PRESCALE_WIDTH-1:0] cnt_r;

  assign bit_done = run && (cnt_r == (prescale - PRESCALE_WIDTH'(1)));

  // Cycle counter; wraps on bit_done so chained bits and frames need no reload.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_r <= '0;
    end else if (!run || bit_done) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Build option: define UART_TX_HOLD_REG_EN for a one-entry request holding register.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  output logic                      TX_OUT,
  output logic                      Busy,
  output logic                      TX_READY
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  state_t                    state_r;
  logic [DATA_WIDTH-1:0]     shift_r;
  logic [DATA_WIDTH-1:0]     next_shift_s;
  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic                      parity_en_r;
  logic                      parity_bit_r;
  logic [CNT_W-1:0]          bit_cnt_r;
  logic                      bit_done_s;
  logic                      accept_s;
  logic                      launch_s;
  logic [DATA_WIDTH-1:0]     src_data_s;
  logic [PRESCALE_WIDTH-1:0] src_prescale_s;
  logic [PRESCALE_WIDTH-1:0] src_prescale_eff_s;
  logic                      src_pe_s;
  logic                      src_pt_s;

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

`ifdef UART_TX_HOLD_REG_EN
  logic                      hold_valid_r;
  logic [DATA_WIDTH-1:0]     hold_data_r;
  logic [PRESCALE_WIDTH-1:0] hold_prescale_r;
  logic                      hold_pe_r;
  logic                      hold_pt_r;

  assign TX_READY = !hold_valid_r;
  assign accept_s = DATA_VALID && !hold_valid_r;
  // A frame starts from idle, or back-to-back at the end of STOP from the hold slot or a same-cycle request.
  assign launch_s = ((state_r == IDLE) && accept_s) ||
                    ((state_r == STOP) && bit_done_s && (hold_valid_r || accept_s));

  // Frame source: the held request has priority over the live inputs.
  always_comb begin
    if (hold_valid_r) begin
      src_data_s     = hold_data_r;
      src_prescale_s = hold_prescale_r;
      src_pe_s       = hold_pe_r;
      src_pt_s       = hold_pt_r;
    end else begin
      src_data_s     = P_DATA;
      src_prescale_s = Prescale;
      src_pe_s       = parity_enable;
      src_pt_s       = parity_type;
    end
  end

  // Holding register: filled by a request that cannot launch at once, drained on launch.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_valid_r    <= 1'b0;
      hold_data_r     <= '0;
      hold_prescale_r <= '0;
      hold_pe_r       <= 1'b0;
      hold_pt_r       <= 1'b0;
    end else if (accept_s && !launch_s) begin
      hold_valid_r    <= 1'b1;
      hold_data_r     <= P_DATA;
      hold_prescale_r <= Prescale;
      hold_pe_r       <= parity_enable;
      hold_pt_r       <= parity_type;
    end else if (launch_s && hold_valid_r) begin
      hold_valid_r    <= 1'b0;
    end else begin
      hold_valid_r    <= hold_valid_r;
    end
  end
`else
  assign TX_READY       = !Busy;
  assign accept_s       = DATA_VALID && (state_r == IDLE);
  assign launch_s       = accept_s;
  assign src_data_s     = P_DATA;
  assign src_prescale_s = Prescale;
  assign src_pe_s       = parity_enable;
  assign src_pt_s       = parity_type;
`endif

  assign src_prescale_eff_s = (src_prescale_s < PRESCALE_WIDTH'(MIN_PRESCALE)) ?
                              PRESCALE_WIDTH'(MIN_PRESCALE) : src_prescale_s;
  assign next_shift_s = shift_r >> 1;

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .CLK     (CLK),
    .RST     (RST),
    .run     (state_r != IDLE),
    .prescale(prescale_r),
    .bit_done(bit_done_s)
  );

  // Per-frame settings captured at launch so later input changes cannot disturb the frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      prescale_r   <= PRESCALE_WIDTH'(MIN_PRESCALE);
      parity_en_r  <= 1'b0;
      parity_bit_r <= 1'b0;
    end else if (launch_s) begin
      prescale_r   <= src_prescale_eff_s;
      parity_en_r  <= src_pe_s;
      parity_bit_r <= parity_of(src_data_s, src_pt_s);
    end else begin
      prescale_r   <= prescale_r;
    end
  end

  // Frame FSM with registered line and busy outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r   <= IDLE;
      TX_OUT    <= STOP_LEVEL;
      Busy      <= 1'b0;
      bit_cnt_r <= '0;
      shift_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            state_r <= START;
            shift_r <= src_data_s;
            TX_OUT  <= START_LEVEL;
            Busy    <= 1'b1;
          end else begin
            TX_OUT  <= STOP_LEVEL;
            Busy    <= 1'b0;
          end
        end
        START: begin
          if (bit_done_s) begin
            state_r   <= DATA;
            bit_cnt_r <= '0;
            TX_OUT    <= shift_r[0];
          end
        end
        DATA: begin
          if (bit_done_s) begin
            if (bit_cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
              if (parity_en_r) begin
                state_r <= PARITY;
                TX_OUT  <= parity_bit_r;
              end else begin
                state_r <= STOP;
                TX_OUT  <= STOP_LEVEL;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              shift_r   <= next_shift_s;
              TX_OUT    <= next_shift_s[0];
            end
          end
        end
        PARITY: begin
          if (bit_done_s) begin
            state_r <= STOP;
            TX_OUT  <= STOP_LEVEL;
          end
        end
        STOP: begin
          if (bit_done_s) begin
            if (launch_s) begin
              state_r <= START;
              shift_r <= src_data_s;
              TX_OUT  <= START_LEVEL;
              Busy    <= 1'b1;
            end else begin
              state_r <= IDLE;
              TX_OUT  <= STOP_LEVEL;
              Busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          TX_OUT  <= STOP_LEVEL;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a level-stream model plus literal frame checks.
// Honours UART_TX_HOLD_REG_EN the same way the design does.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic [PW-1:0] Prescale = 6'd8;
  logic          parity_enable = 1'b0;
  logic          parity_type = 1'b0;
  logic          TX_OUT;
  logic          Busy;
  logic          TX_READY;

  int checks = 0;
  int errors = 0;

  uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .Prescale(Prescale), .parity_enable(parity_enable), .parity_type(parity_type),
    .TX_OUT(TX_OUT), .Busy(Busy), .TX_READY(TX_READY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a queue of line levels, one per cycle, appended whole frames on acceptance.
  typedef struct packed { logic lvl; logic first; } ent_t;
  ent_t q[$];
  logic m_tx = 1'b1;
  logic m_busy = 1'b0;
  int   pending = 0;
  logic chk_en = 1'b0;

  function automatic logic m_ready();
`ifdef UART_TX_HOLD_REG_EN
    return pending == 0;
`else
    return !m_busy;
`endif
  endfunction

  task automatic model_accept();
    logic bits[$];
    int p;
    ent_t e;
    p = (Prescale < 6'd4) ? 4 : int'(Prescale);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(P_DATA[i]);
    if (parity_enable) bits.push_back((^P_DATA) ^ parity_type);
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < p; c++) begin
        e.lvl = bits[b];
        e.first = (b == 0 && c == 0);
        q.push_back(e);
      end
    pending++;
  endtask

  always @(posedge CLK) begin
    ent_t e;
    if (!RST) begin
      q.delete();
      m_tx = 1'b1;
      m_busy = 1'b0;
      pending = 0;
      chk_en = 1'b1;
    end else begin
      if (DATA_VALID && m_ready()) model_accept();
      if (q.size() > 0) begin
        e = q.pop_front();
        m_tx = e.lvl;
        m_busy = 1'b1;
        if (e.first) pending--;
      end else begin
        m_tx = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("tx_out", {31'd0, TX_OUT}, {31'd0, m_tx});
      check("busy", {31'd0, Busy}, {31'd0, m_busy});
      check("tx_ready", {31'd0, TX_READY}, {31'd0, m_ready()});
    end
  end

  // Busy-run length and count of busy rises.
  int   busy_cnt = 0;
  int   last_len = 0;
  int   rises = 0;
  logic prev_busy = 1'b0;
  always @(negedge CLK) begin
    if (Busy === 1'b1) begin
      if (!prev_busy) rises++;
      busy_cnt++;
    end else if (busy_cnt != 0) begin
      last_len = busy_cnt;
      busy_cnt = 0;
    end
    prev_busy = (Busy === 1'b1);
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] pre);
    @(posedge CLK); #1;
    P_DATA = d; parity_enable = pe; parity_type = pt; Prescale = pre; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    P_DATA = ~d; parity_enable = ~pe; parity_type = ~pt; Prescale = 6'd5;
  endtask

  // Sample the middle of each of n bits of period p, starting with the current cycle.
  task automatic capture_bits(input int n, input int p, output logic [15:0] bits);
    bits = '0;
    for (int c = 0; c < n * p; c++) begin
      @(negedge CLK);
      if (c % p == p / 2) bits[c / p] = TX_OUT;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (Busy !== 1'b0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_idle_timeout"}, {31'd0, (n >= 1000)}, 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    logic [15:0] bits;
    int r0;
    int lows;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("reset_tx", {31'd0, TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_ready", {31'd0, TX_READY}, 32'd1);

    send(8'hA5, 1'b1, 1'b0, 6'd8);
    capture_bits(11, 8, bits);
    check("a5_bits", {21'd0, bits[10:0]}, 32'h54A);
    wait_idle("a5");
    check("a5_busy_len", last_len, 32'd88);

    send(8'h01, 1'b1, 1'b1, 6'd4);
    capture_bits(11, 4, bits);
    check("01_parity", {31'd0, bits[9]}, 32'd0);
    check("01_bits", {21'd0, bits[10:0]}, 32'h402);
    wait_idle("01");
    check("01_busy_len", last_len, 32'd44);

    send(8'hFF, 1'b0, 1'b0, 6'd16);
    capture_bits(10, 16, bits);
    check("ff_bits", {22'd0, bits[9:0]}, 32'h3FE);
    wait_idle("ff");
    check("ff_busy_len", last_len, 32'd160);

    send(8'h3C, 1'b0, 1'b1, 6'd2);
    wait_idle("clamp");
    check("clamp_busy_len", last_len, 32'd40);

    send(8'h96, 1'b1, 1'b1, 6'd32);
    wait_idle("p32");
    check("p32_busy_len", last_len, 32'd352);

    // Second request mid-frame.
    r0 = rises;
    send(8'h12, 1'b1, 1'b0, 6'd4);
    repeat (8) @(posedge CLK);
    send(8'h3C, 1'b0, 1'b0, 6'd8);
    wait_idle("midreq");
    check("midreq_rises", rises - r0, 32'd1);
`ifdef UART_TX_HOLD_REG_EN
    check("midreq_len", last_len, 32'd124);
`else
    check("midreq_len", last_len, 32'd44);
`endif

    // Request sampled in the last stop-bit cycle.
    r0 = rises;
    send(8'h0F, 1'b0, 1'b0, 6'd4);
    repeat (39) @(posedge CLK);
    #1 P_DATA = 8'hC3; Prescale = 6'd4; parity_enable = 1'b0; DATA_VALID = 1'b1;
    @(posedge CLK); #1 DATA_VALID = 1'b0;
    wait_idle("laststop");
    check("laststop_rises", rises - r0, 32'd1);
`ifdef UART_TX_HOLD_REG_EN
    check("laststop_len", last_len, 32'd80);
`else
    check("laststop_len", last_len, 32'd40);
`endif

    // 0x55 then 0xAA while busy.
    r0 = rises;
    send(8'h55, 1'b0, 1'b0, 6'd4);
    repeat (5) @(posedge CLK);
    send(8'hAA, 1'b0, 1'b0, 6'd4);
    wait_idle("b2b");
    check("b2b_rises", rises - r0, 32'd1);
`ifdef UART_TX_HOLD_REG_EN
    check("b2b_len", last_len, 32'd80);
`else
    check("b2b_len", last_len, 32'd40);
`endif

    // Reset during data bit 3.
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    repeat (34) @(negedge CLK);
    check("rst_pre_bit3", {31'd0, TX_OUT}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    check("rst_tx", {31'd0, TX_OUT}, 32'd1);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_ready", {31'd0, TX_READY}, 32'd1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1) lows++;
    end
    check("rst_no_bits", lows, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL run on one clock, CLK, and one synchronous, active-low reset, RST.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the payload width in bits.
REQ-003 Parameter PRESCALE_WIDTH, default 6, SHALL set the width of Prescale.
REQ-004 Port CLK  input  1  SHALL be the system clock; all logic SHALL be posedge-triggered.
REQ-005 Port RST  input  1  SHALL be the synchronous active-low reset.
REQ-006 Port P_DATA  input  DATA_WIDTH  SHALL carry the byte to send.
REQ-007 Port DATA_VALID  input  1  SHALL be the request strobe for P_DATA.
REQ-008 Port Prescale  input  PRESCALE_WIDTH  SHALL give the CLK cycles per bit; legal values are 4, 8, 16 and 32.
REQ-009 Port parity_enable  input  1  SHALL be 1 to insert a parity bit.
REQ-010 Port parity_type  input  1  SHALL select the parity: 0 = even, 1 = odd.
REQ-011 Port TX_OUT  output  1  SHALL be the serial line, idle high.
REQ-012 Port Busy  output  1  SHALL be 1 whenever the FSM is not IDLE.
REQ-013 Port TX_READY  output  1  SHALL be 1 when a DATA_VALID in this cycle would be accepted.

Function
REQ-014 A request SHALL be accepted on a posedge where DATA_VALID=1 and TX_READY=1.
- On acceptance, P_DATA, Prescale, parity_enable and parity_type SHALL be captured.
- Later changes to these inputs SHALL NOT affect the frame in flight.
REQ-015 DATA_VALID while TX_READY=0 SHALL be ignored; the request is not stored.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
- IDLE->START on acceptance.
- START->DATA, then DATA for DATA_WIDTH bits, LSB first.
- DATA->PARITY if parity is enabled, otherwise DATA->STOP.
- PARITY->STOP.
- STOP->IDLE, or STOP->START per REQ-024.
REQ-017 Each bit (start, data, parity, stop) SHALL hold TX_OUT for exactly Prescale cycles.
- Timing SHALL use a bit-cycle counter that wraps at Prescale-1.
REQ-018 A captured Prescale below 4 SHALL be treated as 4.
REQ-019 TX_OUT SHALL be registered; the first start-bit cycle SHALL be the cycle after the accepting edge.
REQ-020 Line levels:
- Start bit = 0.
- Stop bit = 1.
- Parity bit = XOR of the data bits for even parity, inverted for odd parity.
REQ-021 Frame length SHALL be (DATA_WIDTH+2+parity_enable)*Prescale cycles.
REQ-022 Busy SHALL rise in the cycle after acceptance and fall in the cycle after the last stop-bit cycle.

Reset
REQ-023 While RST=0 at a posedge, the block SHALL take its reset values on the next cycle:
- TX_OUT=1, Busy=0, TX_READY=1.
- FSM=IDLE, all counters 0.
- Any frame in progress is aborted (no partial stop bit), and any held request is discarded.

Configuration
REQ-024 Macro UART_TX_HOLD_REG_EN SHALL select between two behaviours.
- Defined:
  - A one-entry holding register SHALL be present; TX_READY = holding register empty.
  - A request MAY be accepted while Busy=1.
  - At the end of STOP with the holding register full, the FSM SHALL go directly to START with zero idle cycles.
  - Acceptance in the last STOP cycle SHALL also chain with no gap.
- Undefined:
  - No holding register; TX_READY = !Busy.
  - At least one IDLE cycle SHALL separate frames.

Structure
REQ-025 Package uart_tx_pkg SHALL hold:
- the state enum type;
- the minimum-prescale constant 4;
- the start-bit and stop-bit level constants.
REQ-026 Sub-module uart_tx_bit_timer SHALL hold the prescale counter and produce a one-cycle bit_done pulse.

Verification
REQ-027 0xA5, parity even, Prescale 8 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1, each level held 8 cycles; Busy high for 88 cycles.
REQ-028 0x01, parity odd, Prescale 4 -> parity bit = 0; frame = 44 cycles.
REQ-029 0xFF, parity off, Prescale 16 -> TX_OUT = 0 followed by nine 1s, each held 16 cycles; frame = 160 cycles.
REQ-030 Second DATA_VALID (0x3C) mid-frame with the macro undefined -> it is ignored; only the first frame appears and the line returns to idle high.
REQ-031 RST=0 during data bit 3 -> TX_OUT=1, Busy=0, TX_READY=1 the next cycle; no further frame bits.
REQ-032 Macro defined, 0x55 then 0xAA issued while Busy=1 -> two frames are sent with zero idle cycles between the stop bit and the next start bit.
